// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
//   Shared widths and types for the CPU front end.
//   ADDR_W        : PC / instruction-memory address width
//   INSTR_W       : instruction width
//   PC_RESET      : PC value driven while reset is asserted
//   fetch_entry_t : one fetched instruction tagged with the PC it came from
// ---------------------------------------------------------------------------
package cpu_pkg;

  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 8;

  localparam logic [ADDR_W-1:0] PC_RESET = '0;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// ---------------------------------------------------------------------------
// fetch_fifo
//   Two-entry synchronous FIFO of fetch_entry_t. slot0 is always the head, so
//   the head is available straight from a register with no read pointer.
//   clk   in  : clock
//   flush in  : empties the FIFO; overrides push and pop in the same cycle
//   push  in  : write din at the tail (never asserted when full without pop)
//   pop   in  : remove the head (never asserted when empty)
//   din   in  : entry to push
//   count out : occupancy, 0..2
//   head  out : head entry, all-zero when empty
// ---------------------------------------------------------------------------
module fetch_fifo
  import cpu_pkg::*;
(
  input  logic         clk,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  fetch_entry_t din,
  output logic [1:0]   count,
  output fetch_entry_t head
);

  fetch_entry_t slot0;
  fetch_entry_t slot1;

  // Occupancy is control state and is the only thing flush touches.
  always_ff @(posedge clk) begin
    if (flush) begin
      count <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Slot contents are plain data; stale values are masked by count.
  always_ff @(posedge clk) begin
    if (!flush) begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) slot0 <= din;
          else               slot1 <= din;
        end
        2'b01: begin
          slot0 <= slot1;
        end
        2'b11: begin
          // With one entry the new word becomes the head directly; with two
          // the second entry moves up and the new word takes its place.
          if (count == 2'd1) begin
            slot0 <= din;
          end else begin
            slot0 <= slot1;
            slot1 <= din;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign head = (count != 2'd0) ? slot0 : '0;

endmodule

// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
//   Instruction fetch stage between the PC register and decode. Drives the
//   next PC, issues reads to a synchronous ROM (1-cycle latency), tags the
//   returned words with their PC in a 2-entry buffer and hands them to decode
//   over valid/ready. A taken branch redirects the PC and flushes everything
//   younger than the branch.
//   clk        in  : clock
//   RST        in  : synchronous active-high reset, dominates all inputs
//   pc_in      in  : current PC from the PC register
//   pc_next    out : next PC, to the PC register input (combinational)
//   imem_addr  out : ROM read address (combinational)
//   imem_en    out : ROM read strobe (combinational)
//   imem_rdata in  : ROM data for the read issued last cycle
//   br_valid   in  : taken-branch redirect
//   br_target  in  : redirect target
//   out_valid  out : buffer head valid
//   out_ready  in  : decode accepts the head
//   out_instr  out : head instruction (0 when empty)
//   out_pc     out : head instruction's PC (0 when empty)
// ---------------------------------------------------------------------------
module instr_fetch #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 8,
  parameter int DEPTH   = 2
) (
  input  logic               clk,
  input  logic               RST,
  input  logic [ADDR_W-1:0]  pc_in,
  output logic [ADDR_W-1:0]  pc_next,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic               imem_en,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               br_valid,
  input  logic [ADDR_W-1:0]  br_target,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc
);

  import cpu_pkg::*;

  logic [1:0]        count;
  logic              vld_p1;
  logic [ADDR_W-1:0] pc_p1;
  logic              pop;
  logic              push;
  logic              flush;
  logic              issue;
  logic [2:0]        occ;
  fetch_entry_t      din;
  fetch_entry_t      head;

  assign out_valid = (count != 2'd0);

  // A branch or reset discards the head, so no pop is taken in those cycles.
  assign pop   = out_valid & out_ready & ~br_valid & ~RST;

  // Buffered + in-flight words after this cycle's pop must leave room for
  // the word about to be issued, which is what guarantees no overflow.
  assign occ   = {1'b0, count} + {2'b00, vld_p1} - {2'b00, pop};
  assign issue = ~RST & ~br_valid & (occ < 3'(DEPTH));

  assign push  = vld_p1 & ~br_valid & ~RST;
  assign flush = RST | br_valid;

  assign din.pc    = pc_p1;
  assign din.instr = imem_rdata;

  // Next-PC mux, priority RST > branch > issue > hold.
  always_comb begin
    pc_next   = pc_in;
    imem_addr = pc_in;
    imem_en   = 1'b0;
    if (RST) begin
      pc_next   = PC_RESET;
      imem_addr = PC_RESET;
    end else if (br_valid) begin
      pc_next   = br_target;
    end else if (issue) begin
      pc_next   = pc_in + ADDR_W'(1);
      imem_en   = 1'b1;
    end
  end

  // ---- stage p1: ROM read in flight, data returns next cycle ----
  always_ff @(posedge clk) begin
    if (RST) begin
      vld_p1 <= 1'b0;
      pc_p1  <= PC_RESET;
    end else begin
      vld_p1 <= issue;
      if (issue) pc_p1 <= pc_in;
    end
  end

  // ---- stage p2: returned word captured into the fetch buffer ----
  fetch_fifo u_fifo (
    .clk   (clk),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .din   (din),
    .count (count),
    .head  (head)
  );

  assign out_pc    = head.pc;
  assign out_instr = head.instr;

endmodule

// File: tb/tb_instr_fetch.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch
//   Bench for instr_fetch. Provides a PC register and a synchronous ROM
//   (ROM[a] = a ^ 8'hA5) around the DUT. The reference model tracks the
//   instruction stream abstractly: the PC decode should see next, the words
//   issued but not yet accepted (PC register minus that PC), and whether a
//   read went out last cycle.
// ---------------------------------------------------------------------------
module tb_instr_fetch;

  logic       clk = 1'b0;
  logic       RST;
  logic [7:0] pc_in;
  logic [7:0] pc_next;
  logic [7:0] imem_addr;
  logic       imem_en;
  logic [7:0] imem_rdata;
  logic       br_valid;
  logic [7:0] br_target;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_instr;
  logic [7:0] out_pc;

  int tests = 0;
  int fails = 0;

  // PC register load override, used to start fetching from a chosen PC.
  logic       pc_force_en  = 1'b0;
  logic [7:0] pc_force_val = 8'h00;

  // Reference model state.
  logic [7:0] m_pc;
  logic       m_inflight;
  logic       m_known = 1'b0;

  // Per-cycle expectations and observations.
  logic       e_chk;
  logic       e_valid;
  logic [7:0] e_out_pc;
  logic [7:0] e_out_instr;
  logic       e_acc;
  logic       e_issue;
  logic [7:0] e_pc_next;
  logic [7:0] e_outstanding;
  logic       o_valid;
  logic [7:0] o_out_pc;
  logic [7:0] o_out_instr;
  logic [7:0] o_pc_next;
  logic       o_imem_en;
  logic [7:0] o_imem_addr;
  logic [7:0] o_pc_in;

  always #5 clk = ~clk;

  function automatic logic [7:0] rom_word(input logic [7:0] a);
    return a ^ 8'hA5;
  endfunction

  always @(posedge clk) pc_in <= pc_force_en ? pc_force_val : pc_next;
  always @(posedge clk) if (imem_en) imem_rdata <= rom_word(imem_addr);

  instr_fetch #(.ADDR_W(8), .INSTR_W(8), .DEPTH(2)) dut (
    .clk        (clk),
    .RST        (RST),
    .pc_in      (pc_in),
    .pc_next    (pc_next),
    .imem_addr  (imem_addr),
    .imem_en    (imem_en),
    .imem_rdata (imem_rdata),
    .br_valid   (br_valid),
    .br_target  (br_target),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_instr  (out_instr),
    .out_pc     (out_pc)
  );

  // One clock cycle: drive inputs, compute model expectations and sample the
  // DUT at the falling edge, then advance the model past the rising edge.
  task automatic cycle(input logic r, input logic rdy, input logic br, input logic [7:0] tgt);
    logic [7:0] held;
    RST       = r;
    out_ready = rdy;
    br_valid  = br;
    br_target = tgt;
    @(negedge clk);
    e_outstanding = pc_in - m_pc;
    held          = e_outstanding - {7'd0, m_inflight};
    e_chk         = m_known;
    e_valid       = m_known && (held != 8'd0);
    e_out_pc      = e_valid ? m_pc : 8'd0;
    e_out_instr   = e_valid ? rom_word(m_pc) : 8'd0;
    e_acc         = e_valid && rdy && !br && !r;
    e_issue       = !r && !br && ((e_outstanding - {7'd0, e_acc}) < 8'd2);
    e_pc_next     = r ? 8'd0 : (br ? tgt : (e_issue ? pc_in + 8'd1 : pc_in));
    o_valid       = out_valid;
    o_out_pc      = out_pc;
    o_out_instr   = out_instr;
    o_pc_next     = pc_next;
    o_imem_en     = imem_en;
    o_imem_addr   = imem_addr;
    o_pc_in       = pc_in;
    @(posedge clk);
    #1;
    if (r) begin
      m_pc       = pc_force_en ? pc_force_val : 8'd0;
      m_inflight = 1'b0;
      m_known    = 1'b1;
    end else if (br) begin
      m_pc       = tgt;
      m_inflight = 1'b0;
    end else begin
      if (e_acc) m_pc = m_pc + 8'd1;
      m_inflight = e_issue;
    end
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0, 1'b0, 8'h00);
    cycle(1'b1, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_reset();
    cycle(1'b1, 1'b1, 1'b0, 8'h00);
    cycle(1'b1, 1'b1, 1'b0, 8'h00);
    tests++;
    if ({o_valid, o_out_pc, o_out_instr} !== 17'd0) begin
      fails++;
      $display("FAIL reset_regs: valid/pc/instr=%b/%h/%h required 0/00/00", o_valid, o_out_pc, o_out_instr);
    end
    tests++;
    if ({o_imem_en, o_imem_addr, o_pc_next} !== 17'd0) begin
      fails++;
      $display("FAIL reset_comb: en/addr/pc_next=%b/%h/%h required 0/00/00", o_imem_en, o_imem_addr, o_pc_next);
    end
    // A branch during reset must be ignored.
    cycle(1'b1, 1'b1, 1'b1, 8'h33);
    tests++;
    if (o_pc_next !== 8'h00 || o_imem_en !== 1'b0) begin
      fails++;
      $display("FAIL reset_ignores_branch: pc_next=%h en=%b required 00/0", o_pc_next, o_imem_en);
    end
  endtask

  task automatic test_freerun();
    do_reset();
    for (int k = 0; k < 12; k++) begin
      cycle(1'b0, 1'b1, 1'b0, 8'h00);
      if (k < 2) begin
        tests++;
        if (o_imem_en !== 1'b1 || o_imem_addr !== 8'(k) || o_valid !== 1'b0) begin
          fails++;
          $display("FAIL freerun_startup k=%0d: en=%b addr=%h valid=%b required 1/%h/0", k, o_imem_en, o_imem_addr, o_valid, 8'(k));
        end
      end else begin
        tests++;
        if (o_valid !== 1'b1 || o_out_pc !== 8'(k - 2) || o_out_instr !== (8'(k - 2) ^ 8'hA5)) begin
          fails++;
          $display("FAIL freerun_stream k=%0d: valid=%b pc=%h instr=%h required 1/%h/%h", k, o_valid, o_out_pc, o_out_instr, 8'(k - 2), 8'(k - 2) ^ 8'hA5);
        end
      end
      tests++;
      if (o_pc_next !== o_pc_in + 8'd1) begin
        fails++;
        $display("FAIL freerun_pc_next k=%0d: pc_next=%h required %h", k, o_pc_next, o_pc_in + 8'd1);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] nxt;
    do_reset();
    nxt = 8'd1;
    for (int k = 0; k < 26; k++) begin
      cycle(1'b0, (k < 3 || k >= 10), 1'b0, 8'h00);
      if (k >= 6 && k < 10) begin
        tests++;
        if (o_imem_en !== 1'b0 || o_pc_next !== o_pc_in || o_valid !== 1'b1 || e_outstanding !== 8'd2) begin
          fails++;
          $display("FAIL backpressure_hold k=%0d: en=%b pc_next=%h pc=%h valid=%b held=%0d required 0/%h/1/2", k, o_imem_en, o_pc_next, o_pc_in, o_valid, e_outstanding, o_pc_in);
        end
      end else if (k >= 10) begin
        tests++;
        if (o_valid !== 1'b1 || o_out_pc !== nxt || o_out_instr !== rom_word(nxt)) begin
          fails++;
          $display("FAIL backpressure_resume k=%0d: valid=%b pc=%h instr=%h required 1/%h/%h", k, o_valid, o_out_pc, o_out_instr, nxt, rom_word(nxt));
        end
        nxt = nxt + 8'd1;
      end
    end
  endtask

  task automatic test_branch();
    do_reset();
    for (int k = 0; k < 13; k++) begin
      cycle(1'b0, 1'b1, (k == 5), 8'h40);
      if (k == 5) begin
        tests++;
        if (o_valid !== 1'b1 || o_pc_next !== 8'h40 || o_imem_en !== 1'b0) begin
          fails++;
          $display("FAIL branch_redirect: valid=%b pc_next=%h en=%b required 1/40/0", o_valid, o_pc_next, o_imem_en);
        end
      end else if (k == 6 || k == 7) begin
        tests++;
        if (o_valid !== 1'b0 || (k == 6 && (o_imem_en !== 1'b1 || o_imem_addr !== 8'h40))) begin
          fails++;
          $display("FAIL branch_flush k=%0d: valid=%b en=%b addr=%h required 0 (issue 40 at k=6)", k, o_valid, o_imem_en, o_imem_addr);
        end
      end else if (k >= 8) begin
        tests++;
        if (o_valid !== 1'b1 || o_out_pc !== 8'(8'h40 + k - 8) || o_out_instr !== rom_word(8'(8'h40 + k - 8))) begin
          fails++;
          $display("FAIL branch_target_stream k=%0d: valid=%b pc=%h instr=%h required 1/%h", k, o_valid, o_out_pc, o_out_instr, 8'(8'h40 + k - 8));
        end
      end
    end
  endtask

  task automatic test_wrap();
    logic [7:0] seq [4];
    seq[0] = 8'hFE; seq[1] = 8'hFF; seq[2] = 8'h00; seq[3] = 8'h01;
    pc_force_en  = 1'b1;
    pc_force_val = 8'hFE;
    do_reset();
    pc_force_en  = 1'b0;
    for (int k = 0; k < 8; k++) begin
      cycle(1'b0, 1'b1, 1'b0, 8'h00);
      if (k == 1) begin
        tests++;
        if (o_pc_next !== 8'h00 || o_imem_addr !== 8'hFF) begin
          fails++;
          $display("FAIL wrap_pc_next: pc_next=%h addr=%h required 00/FF", o_pc_next, o_imem_addr);
        end
      end
      if (k >= 2 && k < 6) begin
        tests++;
        if (o_valid !== 1'b1 || o_out_pc !== seq[k-2] || o_out_instr !== rom_word(seq[k-2])) begin
          fails++;
          $display("FAIL wrap_stream k=%0d: valid=%b pc=%h instr=%h required 1/%h", k, o_valid, o_out_pc, o_out_instr, seq[k-2]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int k = 0; k < 8; k++) cycle(1'b0, (k < 3), 1'b0, 8'h00);
    cycle(1'b1, 1'b1, 1'b0, 8'h00);
    tests++;
    if (o_pc_next !== 8'h00 || o_imem_en !== 1'b0 || o_imem_addr !== 8'h00) begin
      fails++;
      $display("FAIL reset_mid_comb: pc_next=%h en=%b addr=%h required 00/0/00", o_pc_next, o_imem_en, o_imem_addr);
    end
    for (int k = 0; k < 5; k++) begin
      cycle(1'b0, 1'b1, 1'b0, 8'h00);
      if (k < 2) begin
        tests++;
        if (o_valid !== 1'b0 || o_out_pc !== 8'h00 || o_out_instr !== 8'h00) begin
          fails++;
          $display("FAIL reset_mid_cleared k=%0d: valid=%b pc=%h instr=%h required 0/00/00", k, o_valid, o_out_pc, o_out_instr);
        end
      end else begin
        tests++;
        if (o_valid !== 1'b1 || o_out_pc !== 8'(k - 2) || o_out_instr !== rom_word(8'(k - 2))) begin
          fails++;
          $display("FAIL reset_mid_restart k=%0d: valid=%b pc=%h instr=%h required 1/%h", k, o_valid, o_out_pc, o_out_instr, 8'(k - 2));
        end
      end
    end
  endtask

  task automatic test_back_to_back_branch();
    do_reset();
    for (int k = 0; k < 4; k++) cycle(1'b0, 1'b1, 1'b0, 8'h00);
    cycle(1'b0, 1'b0, 1'b1, 8'h10);
    tests++;
    if (o_pc_next !== 8'h10 || o_imem_en !== 1'b0) begin
      fails++;
      $display("FAIL b2b_first: pc_next=%h en=%b required 10/0", o_pc_next, o_imem_en);
    end
    cycle(1'b0, 1'b0, 1'b1, 8'h20);
    tests++;
    if (o_pc_next !== 8'h20 || o_imem_en !== 1'b0 || o_pc_in !== 8'h10) begin
      fails++;
      $display("FAIL b2b_second: pc_next=%h en=%b pc=%h required 20/0/10", o_pc_next, o_imem_en, o_pc_in);
    end
    for (int k = 0; k < 10; k++) begin
      cycle(1'b0, 1'b1, 1'b0, 8'h00);
      tests++;
      if (k < 2) begin
        if (o_valid !== 1'b0) begin
          fails++;
          $display("FAIL b2b_gap k=%0d: valid=%b pc=%h required valid 0", k, o_valid, o_out_pc);
        end
      end else if (o_valid !== 1'b1 || o_out_pc !== 8'(8'h20 + k - 2) || o_out_instr !== rom_word(8'(8'h20 + k - 2))) begin
        fails++;
        $display("FAIL b2b_stream k=%0d: valid=%b pc=%h instr=%h required 1/%h", k, o_valid, o_out_pc, o_out_instr, 8'(8'h20 + k - 2));
      end
    end
  endtask

  task automatic test_random();
    logic r, br, rdy;
    logic [7:0] tgt;
    do_reset();
    for (int k = 0; k < 800; k++) begin
      r   = ($urandom_range(199) == 0);
      br  = ($urandom_range(11) == 0);
      rdy = ($urandom_range(3) != 0);
      tgt = 8'($urandom_range(255));
      cycle(r, rdy, br, tgt);
      if (e_chk) begin
        tests++;
        if (o_valid !== e_valid || o_out_pc !== e_out_pc || o_out_instr !== e_out_instr) begin
          fails++;
          $display("FAIL random_head k=%0d: valid/pc/instr=%b/%h/%h required %b/%h/%h", k, o_valid, o_out_pc, o_out_instr, e_valid, e_out_pc, e_out_instr);
        end
      end
      tests++;
      if (o_imem_en !== e_issue || o_pc_next !== e_pc_next) begin
        fails++;
        $display("FAIL random_issue k=%0d: en=%b pc_next=%h required %b/%h", k, o_imem_en, o_pc_next, e_issue, e_pc_next);
      end
      if (e_issue) begin
        tests++;
        if (o_imem_addr !== o_pc_in) begin
          fails++;
          $display("FAIL random_addr k=%0d: addr=%h required %h", k, o_imem_addr, o_pc_in);
        end
      end
    end
  endtask

  initial begin
    RST       = 1'b1;
    out_ready = 1'b0;
    br_valid  = 1'b0;
    br_target = 8'h00;
    test_reset();
    test_freerun();
    test_backpressure();
    test_branch();
    test_wrap();
    test_reset_mid();
    test_back_to_back_branch();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
